// File: rtl/uart_rx_fifo.sv
// UART receiver: 16x oversampled 8N1 deframer feeding a show-ahead FIFO.
// Framing errors and overruns are reported through sticky flags.
module uart_rx_fifo #(
    parameter int clk_freq = 50000000,
    parameter int baud     = 115200,
    parameter int AW       = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rxd,
    input  logic          rd,
    input  logic          clr_err,
    output logic [7:0]    drec,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count,
    output logic          busy,
    output logic          ferr,
    output logic          ovr
);
    localparam int DIV   = clk_freq / (baud * 16);
    localparam int DIVC  = (DIV < 1) ? 1 : DIV;
    localparam int DW    = (DIVC > 1) ? $clog2(DIVC) : 1;
    localparam int DEPTH = 2 ** AW;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIVC - 1);
    localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);

    typedef enum logic [2:0] {
        IDLE, START, DATA, STOP, BRK
    } state_t;

    state_t        state_q, state_d;
    logic          sync1_q, sync2_q;
    logic [DW-1:0] div_q, div_d;
    logic [3:0]    t16_q, t16_d;
    logic [2:0]    bi_q, bi_d;
    logic [7:0]    shift_q, shift_d;
    logic          push_q, push_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic [AW-1:0] rp_q, rp_d;
    logic [AW-1:0] wp_q, wp_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [7:0]    mem [DEPTH];

    logic rx;
    logic tick;
    logic ferr_set;
    logic do_push;
    logic do_pop;

    assign rx      = sync2_q;
    assign tick    = (state_q != IDLE) && (div_q == DIV_LAST);
    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == FULL_CNT);
    assign count   = cnt_q;
    assign busy    = (state_q != IDLE);
    assign ferr    = ferr_q;
    assign ovr     = ovr_q;
    assign drec    = empty ? 8'h00 : mem[rp_q];
    assign do_push = push_q && !full;
    assign do_pop  = rd && !empty;

    // Bring the asynchronous line into the clock domain; idle level is high.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
        end else begin
            sync1_q <= rxd;
            sync2_q <= sync1_q;
        end
    end

    // Deframer next state: tick divider, bit timing and character assembly.
    always_comb begin
        state_d  = state_q;
        div_d    = div_q;
        t16_d    = t16_q;
        bi_d     = bi_q;
        shift_d  = shift_q;
        push_d   = 1'b0;
        ferr_set = 1'b0;
        if (state_q == IDLE || tick) begin
            div_d = '0;
        end else begin
            div_d = div_q + 1'b1;
        end
        unique case (state_q)
            IDLE: begin
                if (!rx) begin
                    state_d = START;
                    t16_d   = 4'd0;
                    div_d   = '0;
                end
            end
            START: begin
                if (tick) begin
                    if (t16_q == 4'd7) begin
                        if (!rx) begin
                            state_d = DATA;
                            t16_d   = 4'd0;
                            bi_d    = 3'd0;
                        end else begin
                            state_d = IDLE;
                        end
                    end else begin
                        t16_d = t16_q + 4'd1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    t16_d = t16_q + 4'd1;
                    if (t16_q == 4'd15) begin
                        shift_d[bi_q] = rx;
                        bi_d          = bi_q + 3'd1;
                        if (bi_q == 3'd7) begin
                            state_d = STOP;
                        end
                    end
                end
            end
            STOP: begin
                if (tick) begin
                    t16_d = t16_q + 4'd1;
                    if (t16_q == 4'd15) begin
                        if (rx) begin
                            push_d  = 1'b1;
                            state_d = IDLE;
                        end else begin
                            ferr_set = 1'b1;
                            state_d  = BRK;
                        end
                    end
                end
            end
            BRK: begin
                if (rx) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO pointer/count update and sticky error flags.
    always_comb begin
        rp_d   = rp_q;
        wp_d   = wp_q;
        cnt_d  = cnt_q;
        ferr_d = (ferr_q && !clr_err) || ferr_set;
        ovr_d  = (ovr_q && !clr_err) || (push_q && full);
        if (do_push) begin
            wp_d = wp_q + 1'b1;
        end
        if (do_pop) begin
            rp_d = rp_q + 1'b1;
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers for deframer and FIFO control.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            div_q   <= '0;
            t16_q   <= 4'd0;
            bi_q    <= 3'd0;
            shift_q <= 8'h00;
            push_q  <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
            rp_q    <= '0;
            wp_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            t16_q   <= t16_d;
            bi_q    <= bi_d;
            shift_q <= shift_d;
            push_q  <= push_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
            rp_q    <= rp_d;
            wp_q    <= wp_d;
            cnt_q   <= cnt_d;
        end
    end

    // Byte storage; contents are don't-care while empty, so no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wp_q] <= shift_q;
        end
    end
endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a byte scoreboard.
// Line rate chosen so DIV=3 (integer-truncated) to keep runs short.
module tb_uart_rx_fifo;
    localparam int CLK  = 50000000;
    localparam int BAUD = 1000000;
    localparam int AW   = 4;
    localparam int DIV  = CLK / (BAUD * 16);
    localparam int BIT  = 16 * DIV;

    logic        clk = 1'b0;
    logic        rst;
    logic        rxd;
    logic        rd;
    logic        clr_err;
    logic [7:0]  drec;
    logic        empty;
    logic        full;
    logic [AW:0] count;
    logic        busy;
    logic        ferr;
    logic        ovr;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q [$];

    uart_rx_fifo #(
        .clk_freq(CLK),
        .baud(BAUD),
        .AW(AW)
    ) dut (
        .clk(clk),
        .rst(rst),
        .rxd(rxd),
        .rd(rd),
        .clr_err(clr_err),
        .drec(drec),
        .empty(empty),
        .full(full),
        .count(count),
        .busy(busy),
        .ferr(ferr),
        .ovr(ovr)
    );

    always #10 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stopb);
        rxd = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (BIT) @(negedge clk);
        end
        rxd = stopb;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic send_good(input logic [7:0] b);
        if (exp_q.size() < 16) exp_q.push_back(b);
        send_byte(b, 1'b1);
    endtask

    task automatic pop(input string tag);
        chk(tag, {24'd0, drec}, {24'd0, exp_q.pop_front()});
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        rxd = 1'b1;
        rd = 1'b0;
        clr_err = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_count", {27'd0, count}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ferr", {31'd0, ferr}, 32'd0);
        chk("rst_ovr", {31'd0, ovr}, 32'd0);
        chk("rst_drec", {24'd0, drec}, 32'd0);
        repeat (5) @(negedge clk);

        send_good(8'h05);
        send_good(8'h0A);
        send_good(8'h0F);
        send_good(8'hFF);
        repeat (4) @(negedge clk);
        chk("b2b_count", {27'd0, count}, 32'd4);
        pop("b2b_d0");
        pop("b2b_d1");
        pop("b2b_d2");
        chk("b2b_drec3", {24'd0, drec}, 32'hFF);
        chk("b2b_cnt1", {27'd0, count}, 32'd1);
        chk("b2b_ferr", {31'd0, ferr}, 32'd0);
        chk("b2b_ovr", {31'd0, ovr}, 32'd0);
        pop("b2b_d3");
        chk("b2b_empty", {31'd0, empty}, 32'd1);

        send_byte(8'h55, 1'b0);
        chk("brk_ferr", {31'd0, ferr}, 32'd1);
        chk("brk_count", {27'd0, count}, 32'd0);
        chk("brk_busy0", {31'd0, busy}, 32'd1);
        repeat (3 * BIT) @(negedge clk);
        chk("brk_busy1", {31'd0, busy}, 32'd1);
        rxd = 1'b1;
        repeat (6) @(negedge clk);
        chk("brk_idle", {31'd0, busy}, 32'd0);
        chk("brk_sticky", {31'd0, ferr}, 32'd1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("brk_clr", {31'd0, ferr}, 32'd0);
        chk("brk_nopush", {31'd0, empty}, 32'd1);

        rxd = 1'b0;
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        chk("gl_busy", {31'd0, busy}, 32'd1);
        repeat (8 * DIV + 10) @(negedge clk);
        chk("gl_idle", {31'd0, busy}, 32'd0);
        chk("gl_count", {27'd0, count}, 32'd0);
        chk("gl_ferr", {31'd0, ferr}, 32'd0);

        for (int i = 0; i < 17; i++) begin
            send_good(i[7:0]);
        end
        repeat (4) @(negedge clk);
        chk("ov_full", {31'd0, full}, 32'd1);
        chk("ov_count", {27'd0, count}, 32'd16);
        chk("ov_ovr", {31'd0, ovr}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            pop($sformatf("ov_d%0d", i));
        end
        chk("ov_empty", {31'd0, empty}, 32'd1);
        rd = 1'b1;
        @(negedge clk);
        rd = 1'b0;
        chk("ov_under", {27'd0, count}, 32'd0);
        chk("ov_udrec", {24'd0, drec}, 32'd0);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        chk("ov_clr", {31'd0, ovr}, 32'd0);

        send_good(8'h11);
        send_good(8'h22);
        send_good(8'h33);
        chk("co_pre", {27'd0, count}, 32'd3);
        fork
            send_good(8'h44);
            begin
                repeat (152 * DIV + 3) @(negedge clk);
                chk("co_drec", {24'd0, drec}, {24'd0, exp_q.pop_front()});
                rd = 1'b1;
                @(negedge clk);
                rd = 1'b0;
                chk("co_count", {27'd0, count}, 32'd3);
            end
        join
        pop("co_d0");
        pop("co_d1");
        pop("co_d2");
        chk("co_empty", {31'd0, empty}, 32'd1);

        send_good(8'h66);
        fork
            send_byte(8'hFC, 1'b1);
            begin
                repeat (3 * BIT + BIT / 2) @(negedge clk);
                rst = 1'b1;
                @(negedge clk);
                rst = 1'b0;
                exp_q.delete();
                chk("mr_count", {27'd0, count}, 32'd0);
                chk("mr_empty", {31'd0, empty}, 32'd1);
                chk("mr_busy", {31'd0, busy}, 32'd0);
                chk("mr_drec", {24'd0, drec}, 32'd0);
                chk("mr_full", {31'd0, full}, 32'd0);
            end
        join
        chk("mr_quiet", {27'd0, count}, 32'd0);
        send_good(8'hA5);
        repeat (2) @(negedge clk);
        chk("mr_cnt1", {27'd0, count}, 32'd1);
        chk("mr_ferr", {31'd0, ferr}, 32'd0);
        pop("mr_a5");
        chk("mr_end", {31'd0, empty}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
